rand_share_arb: RTL and testbench

Shared random-number scheduler. Owns one 8-bit Fibonacci LFSR and hands its low bits out to up to `NUM_REQ` requesters, one grant per cycle, using round-robin arbitration. Typical consumers are the cache replacement-way selectors. The LFSR advances only when a value is consumed, so each grant sees a fresh value. A reseed path loads a software or debug seed and then runs a fixed warm-up before grants resume.

---
 rtl/rand_share_arb_if.sv | 24 ++
 rtl/rand_share_arb.sv | 108 ++++++++++
 tb/tb_rand_share_arb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rand_share_arb_if.sv
// Handshake bundle between the shared LFSR scheduler and its requesters.
// The master side issues requests and reseeds; the slave side (the arbiter) grants and reports status.
interface rand_share_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int OUT_WIDTH = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [OUT_WIDTH-1:0] rand_data;
  logic                 seed_wr;
  logic [7:0]           seed_data;
  logic                 busy;
  logic [7:0]           lfsr_state;

  modport master (
    output req, seed_wr, seed_data,
    input  gnt, rand_data, busy, lfsr_state
  );

  modport slave (
    input  req, seed_wr, seed_data,
    output gnt, rand_data, busy, lfsr_state
  );
endinterface

// File: rtl/rand_share_arb.sv
// Shared 8-bit LFSR handed out round-robin, one registered grant per cycle, 1 cycle after req is seen.
// No backpressure on grants; reseed blocks grants for an 8-cycle warm-up while busy is high.
module rand_share_arb #(
  parameter int         NUM_REQ   = 4,
  parameter int         OUT_WIDTH = 2,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  rand_share_arb_if.slave    bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WARM = 1'b1
  } state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [2:0]           r_warm_cnt;
  logic [PW-1:0]        r_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [OUT_WIDTH-1:0] r_rand;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_idx;
  logic [PW-1:0]        w_ptr_next;
  logic [NUM_REQ-1:0]   w_onehot;
  logic [7:0]           w_lfsr_next;
  logic [7:0]           w_seed;

  assign w_lfsr_next = {r_lfsr[4] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0], r_lfsr[7:1]};
  // A zero seed would lock the LFSR at zero forever.
  assign w_seed      = (bus.seed_data == 8'h00) ? SEED : bus.seed_data;

  // Masking the live grant keeps a requester from being granted twice while it drops req.
  assign w_elig = bus.req & ~r_gnt;

  always_comb begin
    int j;
    w_found = 1'b0;
    w_idx   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_idx   = PW'(j);
      end
    end
  end

  assign w_ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_onehot   = NUM_REQ'(1) << w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED;
      r_warm_cnt <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_rand     <= '0;
      r_busy     <= 1'b0;
    end else if (bus.seed_wr) begin
      r_state    <= WARM;
      r_lfsr     <= w_seed;
      r_warm_cnt <= '0;
      r_gnt      <= '0;
      r_rand     <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        WARM: begin
          r_lfsr     <= w_lfsr_next;
          r_warm_cnt <= r_warm_cnt + 3'd1;
          r_gnt      <= '0;
          r_rand     <= '0;
          if (r_warm_cnt == 3'd7) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (w_found) begin
            r_gnt  <= w_onehot;
            r_rand <= r_lfsr[OUT_WIDTH-1:0];
            r_lfsr <= w_lfsr_next;
            r_ptr  <= w_ptr_next;
          end else begin
            r_gnt  <= '0;
            r_rand <= '0;
          end
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.rand_data  = r_rand;
  assign bus.busy       = r_busy;
  assign bus.lfsr_state = r_lfsr;

endmodule

// File: tb/tb_rand_share_arb.sv
// Directed bench for rand_share_arb: expected grants are queued at stimulus time and checked by a monitor.
module tb_rand_share_arb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [5:0] exp_q[$];

  rand_share_arb_if #(.NUM_REQ(4), .OUT_WIDTH(2)) bus ();

  rand_share_arb #(.NUM_REQ(4), .OUT_WIDTH(2), .SEED(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every grant pops one expectation; warm-up must stay silent.
  always @(negedge clk) begin
    if (bus.busy === 1'b1)
      check("warm_quiet", 32'({bus.gnt, bus.rand_data}), 32'd0);
    if (bus.gnt !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'({bus.gnt, bus.rand_data}), 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("gnt_rand", 32'({bus.gnt, bus.rand_data}), 32'(e));
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.seed_wr   = 1'b0;
    bus.seed_data = 8'h00;
    cyc(2);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rand", 32'(bus.rand_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_lfsr", 32'(bus.lfsr_state), 32'h01);
    rst = 1'b0;

    // Two single grants from requester 0: lfsr 01 -> 80 -> 40.
    bus.req = 4'b0001;
    exp_q.push_back({4'b0001, 2'b01});
    cyc(1);
    bus.req = 4'b0000;
    cyc(1);
    check("t1_lfsr_a", 32'(bus.lfsr_state), 32'h80);
    bus.req = 4'b0001;
    exp_q.push_back({4'b0001, 2'b00});
    cyc(1);
    bus.req = 4'b0000;
    cyc(1);
    check("t1_lfsr_b", 32'(bus.lfsr_state), 32'h40);

    // Round-robin from a fresh reset with all requesters active.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.req = 4'b1111;
    exp_q.push_back({4'b0001, 2'b01});
    exp_q.push_back({4'b0010, 2'b00});
    exp_q.push_back({4'b0100, 2'b00});
    exp_q.push_back({4'b1000, 2'b00});
    exp_q.push_back({4'b0001, 2'b00});
    cyc(5);
    bus.req = 4'b0000;
    cyc(1);
    check("t2_lfsr", 32'(bus.lfsr_state), 32'h88);

    // Requester 2 keeps req high: pulses must be separated by an idle cycle.
    bus.req = 4'b0100;
    exp_q.push_back({4'b0100, 2'b00});
    exp_q.push_back({4'b0100, 2'b00});
    cyc(1);
    check("t3_pulse1", 32'(bus.gnt), 32'h4);
    cyc(1);
    check("t3_gap", 32'(bus.gnt), 32'h0);
    cyc(1);
    check("t3_pulse2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    cyc(1);
    check("t3_lfsr", 32'(bus.lfsr_state), 32'hE2);

    // Zero seed falls back to 01; eight advances land on 71.
    bus.seed_wr   = 1'b1;
    bus.seed_data = 8'h00;
    cyc(1);
    bus.seed_wr = 1'b0;
    check("t4_busy0", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("t4_busy", 32'(bus.busy), 32'd1);
    end
    cyc(1);
    check("t4_busy_fall", 32'(bus.busy), 32'd0);
    check("t4_lfsr", 32'(bus.lfsr_state), 32'h71);
    bus.req = 4'b0001;
    exp_q.push_back({4'b0001, 2'b01});
    cyc(1);
    bus.req = 4'b0000;
    cyc(1);

    // Seed collides with a request, then a second strobe restarts warm-up.
    bus.req       = 4'b0001;
    bus.seed_wr   = 1'b1;
    bus.seed_data = 8'h10;
    cyc(1);
    bus.seed_wr = 1'b0;
    check("t5_no_gnt", 32'(bus.gnt), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd1);
    cyc(2);
    bus.seed_wr = 1'b1;
    cyc(1);
    bus.seed_wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("t5_busy_ext", 32'(bus.busy), 32'd1);
    end
    exp_q.push_back({4'b0001, 2'b11});
    cyc(1);
    check("t5_busy_fall", 32'(bus.busy), 32'd0);
    check("t5_lfsr", 32'(bus.lfsr_state), 32'h47);
    cyc(1);
    bus.req = 4'b0000;
    cyc(1);

    // Reset during warm-up; pointer must be back at requester 0.
    bus.seed_wr   = 1'b1;
    bus.seed_data = 8'h55;
    cyc(1);
    bus.seed_wr = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_gnt", 32'(bus.gnt), 32'd0);
    check("t6_lfsr", 32'(bus.lfsr_state), 32'h01);
    bus.req = 4'b1111;
    exp_q.push_back({4'b0001, 2'b01});
    cyc(1);
    bus.req = 4'b0000;
    cyc(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
